mig_app_model: RTL

// Cycle-level behavioural responder for the MIG 7-series app_* interface, backed by on-chip RAM.

---
 rtl/mig_app_model_if.sv | 34 +++
 rtl/mig_app_model.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mig_app_model_if.sv
// MIG 7-series app_* bus bundle shared by the user logic (master) and the
// memory-side responder (slave).
interface mig_app_model_if #(
   parameter int APP_ADDR_WIDTH = 28,
   parameter int APP_CMD_WIDTH  = 3,
   parameter int APP_DATA_WIDTH = 128,
   parameter int APP_MASK_WIDTH = 16
);
   logic [APP_ADDR_WIDTH-1:0] app_addr;
   logic [APP_CMD_WIDTH-1:0]  app_cmd;
   logic                      app_en;
   logic [APP_DATA_WIDTH-1:0] app_wdf_data;
   logic                      app_wdf_end;
   logic                      app_wdf_wren;
   logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
   logic [APP_DATA_WIDTH-1:0] app_rd_data;
   logic                      app_rd_data_valid;
   logic                      app_rd_data_end;
   logic                      app_rdy;
   logic                      app_wdf_rdy;
   logic                      init_calib_complete;

   modport master (
      output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
      input  app_rd_data, app_rd_data_valid, app_rd_data_end, app_rdy, app_wdf_rdy,
             init_calib_complete
   );

   modport slave (
      input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_end, app_wdf_wren, app_wdf_mask,
      output app_rd_data, app_rd_data_valid, app_rd_data_end, app_rdy, app_wdf_rdy,
             init_calib_complete
   );
endinterface

// File: rtl/mig_app_model.sv
// RAM-backed stand-in for the MIG app_* interface: calibration delay, optional
// app_rdy stalls, split command/data write handling and fixed-latency reads.
module mig_app_model #(
   parameter int APP_ADDR_WIDTH = 28,
   parameter int APP_CMD_WIDTH  = 3,
   parameter int APP_DATA_WIDTH = 128,
   parameter int APP_MASK_WIDTH = 16,
   parameter int MEM_WORDS_LOG2 = 10,
   parameter int CALIB_CYCLES   = 64,
   parameter int RD_LATENCY     = 8,
   parameter int STALL_PERIOD   = 0
) (
   input logic            clk,
   input logic            i_rst,
   mig_app_model_if.slave app
);
   localparam int DEPTH = 1 << MEM_WORDS_LOG2;
   localparam int CCW   = $clog2(CALIB_CYCLES + 1);
   localparam int SPW   = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [0:0] PH_CALIB = 1'b0;
   localparam logic [0:0] PH_RUN   = 1'b1;
   localparam logic [APP_CMD_WIDTH-1:0] CMD_WR = '0;
   localparam logic [APP_CMD_WIDTH-1:0] CMD_RD = APP_CMD_WIDTH'(1);

   logic [0:0]                phase_q, phase_d;
   logic [CCW-1:0]            cal_cnt_q, cal_cnt_d;
   logic [SPW-1:0]            stall_cnt_q, stall_cnt_d;
   logic                      stall_d;
   logic                      rdy_q, rdy_d, wdf_rdy_q, wdf_rdy_d;
   logic                      wcmd_pend_q, wcmd_pend_d;
   logic [MEM_WORDS_LOG2-1:0] pend_idx_q, pend_idx_d;
   logic                      wbuf_full_q, wbuf_full_d;
   logic [APP_DATA_WIDTH-1:0] wbuf_data_q, wbuf_data_d;
   logic [APP_MASK_WIDTH-1:0] wbuf_mask_q, wbuf_mask_d;
   logic [RD_LATENCY-1:0]     vld_pipe_q, vld_pipe_d;
   logic [RD_LATENCY-1:0][APP_DATA_WIDTH-1:0] dat_pipe_q, dat_pipe_d;

   logic [APP_DATA_WIDTH-1:0] mem [DEPTH];
   logic                      cmd_acc, dat_acc, wr_cmd, rd_cmd;
   logic [MEM_WORDS_LOG2-1:0] req_idx;
   logic [APP_DATA_WIDTH-1:0] rd_word;
   logic                      commit_en;
   logic [MEM_WORDS_LOG2-1:0] commit_idx;
   logic [APP_DATA_WIDTH-1:0] commit_data;
   logic [APP_MASK_WIDTH-1:0] commit_mask;
   logic                      unused_in;

   // wdf_end is implied by wren (single-beat bursts); address bits outside the index are ignored
   assign unused_in = ^{app.app_wdf_end, app.app_addr[2:0],
                        app.app_addr[APP_ADDR_WIDTH-1:MEM_WORDS_LOG2+3]};

   assign cmd_acc = app.app_en && rdy_q;
   assign dat_acc = app.app_wdf_wren && wdf_rdy_q;
   assign wr_cmd  = cmd_acc && (app.app_cmd == CMD_WR);
   assign rd_cmd  = cmd_acc && (app.app_cmd == CMD_RD);
   assign req_idx = app.app_addr[MEM_WORDS_LOG2+2:3];
   assign rd_word = mem[req_idx];

   // Calibration phase counter and free-running stall counter
   always_comb begin
      phase_d     = phase_q;
      cal_cnt_d   = cal_cnt_q;
      stall_cnt_d = '0;
      stall_d     = 1'b0;
      if (phase_q == PH_CALIB) begin
         if (cal_cnt_q == CCW'(CALIB_CYCLES - 1)) phase_d = PH_RUN;
         else                                      cal_cnt_d = cal_cnt_q + 1'b1;
      end
      if (STALL_PERIOD > 0) begin
         stall_cnt_d = (stall_cnt_q == SPW'(STALL_PERIOD - 1)) ? '0 : stall_cnt_q + 1'b1;
         stall_d     = (stall_cnt_d == SPW'(STALL_PERIOD - 1));
      end
   end

   // Write pairing: command and data may arrive together or in either order;
   // the RAM is only written once both halves have been accepted.
   always_comb begin
      wcmd_pend_d = wcmd_pend_q;
      pend_idx_d  = pend_idx_q;
      wbuf_full_d = wbuf_full_q;
      wbuf_data_d = wbuf_data_q;
      wbuf_mask_d = wbuf_mask_q;
      commit_en   = 1'b0;
      commit_idx  = req_idx;
      commit_data = app.app_wdf_data;
      commit_mask = app.app_wdf_mask;
      if (wr_cmd) begin
         if (wbuf_full_q) begin
            commit_en   = 1'b1;
            commit_data = wbuf_data_q;
            commit_mask = wbuf_mask_q;
            wbuf_full_d = 1'b0;
         end else if (dat_acc) begin
            commit_en = 1'b1;
         end else begin
            wcmd_pend_d = 1'b1;
            pend_idx_d  = req_idx;
         end
      end else if (dat_acc) begin
         if (wcmd_pend_q) begin
            commit_en   = 1'b1;
            commit_idx  = pend_idx_q;
            wcmd_pend_d = 1'b0;
         end else begin
            wbuf_full_d = 1'b1;
            wbuf_data_d = app.app_wdf_data;
            wbuf_mask_d = app.app_wdf_mask;
         end
      end
      // readies are registered, so they are computed from next-cycle state
      rdy_d     = (phase_d == PH_RUN) && !wcmd_pend_d && !stall_d;
      wdf_rdy_d = (phase_d == PH_RUN) && !wbuf_full_d;
   end

   // Read latency pipeline; idle slots carry zero data
   always_comb begin
      vld_pipe_d    = '0;
      dat_pipe_d    = '0;
      vld_pipe_d[0] = rd_cmd;
      dat_pipe_d[0] = rd_cmd ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
         vld_pipe_d[i] = vld_pipe_q[i-1];
         dat_pipe_d[i] = dat_pipe_q[i-1];
      end
   end

   // Control and pipeline registers
   always_ff @(posedge clk) begin
      if (i_rst) begin
         phase_q     <= PH_CALIB;
         cal_cnt_q   <= '0;
         stall_cnt_q <= '0;
         rdy_q       <= 1'b0;
         wdf_rdy_q   <= 1'b0;
         wcmd_pend_q <= 1'b0;
         pend_idx_q  <= '0;
         wbuf_full_q <= 1'b0;
         wbuf_data_q <= '0;
         wbuf_mask_q <= '0;
         vld_pipe_q  <= '0;
         dat_pipe_q  <= '0;
      end else begin
         phase_q     <= phase_d;
         cal_cnt_q   <= cal_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         rdy_q       <= rdy_d;
         wdf_rdy_q   <= wdf_rdy_d;
         wcmd_pend_q <= wcmd_pend_d;
         pend_idx_q  <= pend_idx_d;
         wbuf_full_q <= wbuf_full_d;
         wbuf_data_q <= wbuf_data_d;
         wbuf_mask_q <= wbuf_mask_d;
         vld_pipe_q  <= vld_pipe_d;
         dat_pipe_q  <= dat_pipe_d;
      end
   end

   // Byte-masked RAM write; contents survive reset, but a write racing reset is dropped
   always_ff @(posedge clk) begin
      if (commit_en && !i_rst) begin
         for (int b = 0; b < APP_MASK_WIDTH; b++) begin
            if (!commit_mask[b]) mem[commit_idx][b*8 +: 8] <= commit_data[b*8 +: 8];
         end
      end
   end

   assign app.app_rd_data         = dat_pipe_q[RD_LATENCY-1];
   assign app.app_rd_data_valid   = vld_pipe_q[RD_LATENCY-1];
   assign app.app_rd_data_end     = vld_pipe_q[RD_LATENCY-1];
   assign app.app_rdy             = rdy_q;
   assign app.app_wdf_rdy         = wdf_rdy_q;
   assign app.init_calib_complete = (phase_q == PH_RUN);
endmodule
